// File: rtl/step_dir_receiver_pkg.sv
// Shared defaults and sizing helper for the STEP/DIR/EN receiver.
package step_dir_pkg;

    localparam int FILTER_LEN_DEF = 4;
    localparam int DIR_SETUP_DEF  = 8;
    localparam int POS_WIDTH_DEF  = 32;

    // Bits needed to hold the values 0..n, i.e. ceil(log2(n+1)), minimum 1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n + 1) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/step_dir_receiver_if.sv
// Motor-line inputs, control pulses and decoded status of the receiver.
interface step_dir_receiver_if #(
    parameter int POS_WIDTH = step_dir_pkg::POS_WIDTH_DEF
);
    logic                        step_in;
    logic                        dir_in;
    logic                        en_in;
    logic                        clear;
    logic                        err_clear;
    logic signed [POS_WIDTH-1:0] position;
    logic                        step_pulse;
    logic                        dir_q;
    logic                        en_q;
    logic                        setup_err;

    modport master (
        output step_in, dir_in, en_in, clear, err_clear,
        input  position, step_pulse, dir_q, en_q, setup_err
    );

    modport slave (
        input  step_in, dir_in, en_in, clear, err_clear,
        output position, step_pulse, dir_q, en_q, setup_err
    );
endinterface

// File: rtl/step_dir_receiver_sync_filter.sv
// Purpose: 2-flop synchroniser plus glitch filter for one asynchronous line.
// Latency: 1+FILTER_LEN cycles from first sampling edge to q_filt flip.
// Backpressure: none; free-running per clock.
module sync_filter
    import step_dir_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic d_async,
    output logic q_filt
);

    localparam int            CW   = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            q_filt <= 1'b0;
        end else begin
            s1 <= d_async;
            s2 <= s1;
            // Any agreeing cycle restarts the count, so only an unbroken run flips q_filt.
            if (s2 == q_filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q_filt <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_dir_receiver.sv
// Purpose: filter STEP/DIR/EN, count STEP rises into a signed position, flag DIR setup violations.
// Latency: position/step_pulse update 2+FILTER_LEN cycles after a STEP rise is first sampled.
// Backpressure: none; at most one counted step per two cycles.
module step_dir_receiver
    import step_dir_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int POS_WIDTH  = POS_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    step_dir_receiver_if.slave   bus
);

    localparam int            SW        = cnt_width(DIR_SETUP);
    localparam logic [SW-1:0] SETUP_MAX = SW'(DIR_SETUP);

    logic                 step_f;
    logic                 dir_f;
    logic                 en_f;
    logic                 step_d;
    logic                 dir_d;
    logic [SW-1:0]        dir_stable;
    logic [POS_WIDTH-1:0] pos;
    logic                 pulse;
    logic                 err;

    logic step_rise;
    logic take;
    logic late;

    sync_filter #(.FILTER_LEN(FILTER_LEN)) u_step (
        .clock(clock), .reset(reset), .d_async(bus.step_in), .q_filt(step_f)
    );
    sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dir (
        .clock(clock), .reset(reset), .d_async(bus.dir_in), .q_filt(dir_f)
    );
    sync_filter #(.FILTER_LEN(FILTER_LEN)) u_en (
        .clock(clock), .reset(reset), .d_async(bus.en_in), .q_filt(en_f)
    );

    // A clear in the same cycle drops the step completely: no count, pulse or error.
    assign step_rise = step_f & ~step_d;
    assign take      = step_rise & en_f & ~bus.clear;
    assign late      = (dir_stable < SETUP_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_d     <= 1'b0;
            dir_d      <= 1'b0;
            dir_stable <= '0;
            pos        <= '0;
            pulse      <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_d <= step_f;
            dir_d  <= dir_f;

            if (dir_f != dir_d) begin
                dir_stable <= '0;
            end else if (dir_stable != SETUP_MAX) begin
                dir_stable <= dir_stable + 1'b1;
            end

            if (bus.clear) begin
                pos <= '0;
            end else if (take) begin
                pos <= dir_f ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
            end

            pulse <= take;

            // A fresh violation outranks err_clear.
            if (take && late) begin
                err <= 1'b1;
            end else if (bus.err_clear) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.position   = pos;
    assign bus.step_pulse = pulse;
    assign bus.dir_q      = dir_f;
    assign bus.en_q       = en_f;
    assign bus.setup_err  = err;

endmodule
